mult_div_unit: RTL and testbench

//  Multi-cycle HI/LO multiply/divide unit serving MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.

---
 rtl/mult_div_if.sv | 27 ++
 rtl/mult_div_unit.sv | 169 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_if.sv
// Execute-stage handshake between the pipeline and the HI/LO multiply/divide unit.
// The master drives operation requests and HI/LO moves; the slave returns HI/LO and status.
interface mult_div_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             busy;
  logic             done;

  modport master (
    output start, op, A, B, hi_we, lo_we, wdata,
    input  HI, LO, busy, done
  );

  modport slave (
    input  start, op, A, B, hi_we, lo_we, wdata,
    output HI, LO, busy, done
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, sign correction applied when the result is committed to HI/LO.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  mult_div_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic             is_div_reg;
  logic             sign_a_reg;
  logic             sign_b_reg;
  logic             div_zero_reg;
  logic [WIDTH-1:0] hi_acc_reg;
  logic [WIDTH-1:0] lo_acc_reg;
  logic [WIDTH-1:0] opnd_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             commit_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             accept;
  logic             move_ok;
  logic             last_iter;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] hi_acc_next;
  logic [WIDTH-1:0] lo_acc_next;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  // The cycle after FIX is still reported busy so the commit edge lands two edges after the last iteration.
  always_comb begin
    accept     = (state_reg == IDLE) && !busy_reg && bus.start;
    move_ok    = (state_reg == IDLE) && !busy_reg && !bus.start;
    last_iter  = (cnt_reg == CW'(WIDTH - 1));
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (last_iter) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    sign_a = bus.op[0] & bus.A[WIDTH-1];
    sign_b = bus.op[0] & bus.B[WIDTH-1];
    abs_a  = sign_a ? -bus.A : bus.A;
    abs_b  = sign_b ? -bus.B : bus.B;
  end

  // With a zero divisor every trial succeeds or restores the same bits, so HI still ends up as |A|.
  always_comb begin
    mul_sum     = {1'b0, hi_acc_reg} + (lo_acc_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
    div_shift   = {hi_acc_reg, lo_acc_reg[WIDTH-1]};
    div_diff    = div_shift - {1'b0, opnd_reg};
    hi_acc_next = hi_acc_reg;
    lo_acc_next = lo_acc_reg;
    if (is_div_reg) begin
      hi_acc_next = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      lo_acc_next = {lo_acc_reg[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      hi_acc_next = mul_sum[WIDTH:1];
      lo_acc_next = {mul_sum[0], lo_acc_reg[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_neg = -{hi_acc_reg, lo_acc_reg};
    fix_hi   = hi_acc_reg;
    fix_lo   = lo_acc_reg;
    if (is_div_reg) begin
      fix_hi = sign_a_reg ? -hi_acc_reg : hi_acc_reg;
      if (div_zero_reg) begin
        fix_lo = {WIDTH{1'b1}};
      end else if (sign_a_reg ^ sign_b_reg) begin
        fix_lo = -lo_acc_reg;
      end
    end else if (sign_a_reg ^ sign_b_reg) begin
      fix_hi = prod_neg[2*WIDTH-1:WIDTH];
      fix_lo = prod_neg[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_div_reg   <= 1'b0;
      sign_a_reg   <= 1'b0;
      sign_b_reg   <= 1'b0;
      div_zero_reg <= 1'b0;
      hi_acc_reg   <= '0;
      lo_acc_reg   <= '0;
      opnd_reg     <= '0;
      cnt_reg      <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      commit_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      busy_reg   <= (state_reg != IDLE);
      commit_reg <= (state_reg == FIX);
      done_reg   <= commit_reg;
      unique case (state_reg)
        IDLE: begin
          if (accept) begin
            is_div_reg   <= bus.op[1];
            sign_a_reg   <= sign_a;
            sign_b_reg   <= sign_b;
            div_zero_reg <= bus.op[1] && (bus.B == '0);
            hi_acc_reg   <= '0;
            lo_acc_reg   <= bus.op[1] ? abs_a : abs_b;
            opnd_reg     <= bus.op[1] ? abs_b : abs_a;
            cnt_reg      <= '0;
          end
        end
        CALC: begin
          hi_acc_reg <= hi_acc_next;
          lo_acc_reg <= lo_acc_next;
          cnt_reg    <= cnt_reg + CW'(1);
        end
        default: begin
        end
      endcase
      // Accumulators hold their final values until the next accept, which busy blocks during commit.
      if (commit_reg) begin
        hi_reg <= fix_hi;
        lo_reg <= fix_lo;
      end else if (move_ok) begin
        if (bus.hi_we) hi_reg <= bus.wdata;
        if (bus.lo_we) lo_reg <= bus.wdata;
      end
    end
  end

  assign bus.HI   = hi_reg;
  assign bus.LO   = lo_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO come from a native-arithmetic model,
// are queued at launch and compared when the unit raises done.
module tb_mult_div_unit;

  localparam int WIDTH = 32;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  exp_t sb_q[$];

  mult_div_if #(.WIDTH(WIDTH)) bus ();

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] p;
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin
        p  = {32'b0, a} * {32'b0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      2'b01: begin
        p  = 64'(sa * sb);
        hi = p[63:32];
        lo = p[31:0];
      end
      2'b10: begin
        if (b == 0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else begin
          hi = a % b;
          lo = a / b;
        end
      end
      default: begin
        if (b == 0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else begin
          q  = sa / sb;
          r  = sa % sb;
          hi = r[31:0];
          lo = q[31:0];
        end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stray_start_at, input int stray_we_at, input bit we_with_start);
    exp_t        e;
    logic [31:0] hi_before;
    int          busy_cnt;
    int          lat;
    bit          seen;
    model(op, a, b, e.hi, e.lo);
    e.op = op;
    e.a  = a;
    e.b  = b;
    sb_q.push_back(e);
    hi_before = bus.HI;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    if (we_with_start) begin
      bus.hi_we = 1'b1;
      bus.wdata = 32'hDEAD_BEEF;
    end
    tick();
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.op    = ~op;
    bus.A     = $urandom;
    bus.B     = $urandom;
    if (we_with_start) check_val("start_wins_hi", bus.HI, hi_before);
    busy_cnt = 0;
    lat      = 0;
    seen     = 1'b0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      tick();
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        seen = 1'b1;
        lat  = k;
      end
      if (k == stray_start_at) begin
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.A     = 32'd1;
        bus.B     = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
      if (k == stray_we_at) begin
        bus.hi_we = 1'b1;
        bus.wdata = 32'hBAD0_0BAD;
      end else if (k == stray_we_at + 1) begin
        bus.hi_we = 1'b0;
        check_val("busy_we_dropped", bus.HI, hi_before);
      end
    end
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    check_val("done_seen", seen, 1);
    e = sb_q.pop_front();
    $display("op=%0d A=%h B=%h -> HI=%h LO=%h latency=%0d busy_cycles=%0d",
             e.op, e.a, e.b, bus.HI, bus.LO, lat, busy_cnt);
    if (seen) begin
      check_val("hi", bus.HI, e.hi);
      check_val("lo", bus.LO, e.lo);
      check_val("latency", lat, 34);
      check_val("busy_cycles", busy_cnt, 33);
      check_val("busy_low_at_done", bus.busy, 0);
      tick();
      check_val("done_one_cycle", bus.done, 0);
    end
  endtask

  task automatic move(input bit hw, input bit lw, input logic [31:0] data);
    bus.hi_we = hw;
    bus.lo_we = lw;
    bus.wdata = data;
    tick();
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    $display("move hi_we=%0d lo_we=%0d wdata=%h -> HI=%h LO=%h", hw, lw, data, bus.HI, bus.LO);
    check_val("move_no_done", bus.done, 0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.A     = '0;
    bus.B     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (3) tick();
    check_val("rst_hi", bus.HI, 0);
    check_val("rst_lo", bus.LO, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_done", bus.done, 0);
    rst_n = 1'b1;
    tick();

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -10, -10, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5, -10, -10, 1'b0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, -10, -10, 1'b0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -10, -10, 1'b0);
    run_op(2'b10, 32'd7, 32'd0, 5, -10, 1'b0);
    run_op(2'b11, 32'hFFFF_FFF0, 32'd0, -10, -10, 1'b0);

    move(1'b1, 1'b0, 32'h0000_1234);
    check_val("mthi_hi", bus.HI, 32'h0000_1234);
    move(1'b0, 1'b1, 32'h0000_5678);
    check_val("mtlo_hi_kept", bus.HI, 32'h0000_1234);
    check_val("mtlo_lo", bus.LO, 32'h0000_5678);
    move(1'b1, 1'b1, 32'hCAFE_F00D);
    check_val("both_hi", bus.HI, 32'hCAFE_F00D);
    check_val("both_lo", bus.LO, 32'hCAFE_F00D);

    run_op(2'b01, 32'd1000, 32'hFFFF_FF00, -10, 12, 1'b0);
    run_op(2'b10, 32'd1000, 32'd33, -10, -10, 1'b1);

    // Abort an in-flight divide with reset.
    bus.op    = 2'b10;
    bus.A     = 32'd100;
    bus.B     = 32'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    $display("reset mid-op -> HI=%h LO=%h busy=%0d done=%0d", bus.HI, bus.LO, bus.busy, bus.done);
    check_val("abort_hi", bus.HI, 0);
    check_val("abort_lo", bus.LO, 0);
    check_val("abort_busy", bus.busy, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (30) begin
      tick();
      check_val("abort_no_done", bus.done, 0);
    end
    run_op(2'b10, 32'd100, 32'd7, -10, -10, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 300)));
      run_op(rop, ra, rb, -10, -10, 1'b0);
    end

    check_val("queue_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
